// File: rtl/vec_out_mem.sv
// Vector-lane output frame memory: masked multi-lane word writes, and a drain that
// streams the first L words pixel by pixel (lane 0 first) over valid/ready on a startIO rising edge.
module vec_out_mem #(
    parameter  int ADDR_W = 24,
    parameter  int DEPTH  = 10000,
    parameter  int PIXEL  = 8,
    parameter  int LANES  = 3,
    localparam int WORD_W = LANES * PIXEL,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] wd,
    input  logic [LANES-1:0]  wmask,
    output logic              wr_err,
    input  logic              startIO,
    input  logic [ADDR_W-1:0] drain_len,
    output logic [PIXEL-1:0]  out_pixel,
    output logic [ADDR_W-1:0] out_addr,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_start_d;
    logic              r_wr_err;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_word;
    logic [LANE_W-1:0] r_lane;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_start_edge;
    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_len_clip;
    logic              w_hs;
    logic              w_last_lane;
    logic              w_last_word;
    logic [MEM_AW-1:0] w_waddr;
    logic [MEM_AW-1:0] w_raddr;
    logic [PIXEL-1:0]  w_lane_pix;

    assign w_busy       = (r_state == ST_READ) || (r_state == ST_STREAM);
    assign w_start_edge = startIO && !r_start_d;
    assign w_wr_ok      = we && !w_busy && (address < DEPTH_A);
    assign w_len_clip   = (drain_len > DEPTH_A) ? DEPTH_A : drain_len;
    assign w_hs         = (r_state == ST_STREAM) && out_ready;
    assign w_last_lane  = (r_lane == LAST_LANE);
    assign w_last_word  = (r_word == (r_len - ADDR_W'(1)));
    assign w_waddr      = address[MEM_AW-1:0];
    assign w_raddr      = r_word[MEM_AW-1:0];

    // Storage has no reset; the read register only matters in STREAM where it is always freshly loaded.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_wr_ok && wmask[i]) begin
                r_mem[w_waddr][i*PIXEL +: PIXEL] <= wd[i*PIXEL +: PIXEL];
            end
        end
        if (r_state == ST_READ) begin
            r_rdata <= r_mem[w_raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_next = (w_len_clip == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ:   w_next = ST_STREAM;
            ST_STREAM: begin
                if (w_hs && w_last_lane) begin
                    w_next = w_last_word ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // The edge register tracks startIO every cycle, so a level held across a drain cannot retrigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
            r_wr_err  <= 1'b0;
            r_len     <= '0;
            r_word    <= '0;
            r_lane    <= '0;
        end else begin
            r_start_d <= startIO;
            r_wr_err  <= we && !w_wr_ok;
            if ((r_state == ST_IDLE) && w_start_edge) begin
                r_len  <= w_len_clip;
                r_word <= '0;
                r_lane <= '0;
            end else if (w_hs) begin
                if (w_last_lane) begin
                    r_lane <= '0;
                    r_word <= r_word + ADDR_W'(1);
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_lane_pix = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_lane_pix = r_rdata[i*PIXEL +: PIXEL];
            end
        end
    end

    assign wr_err    = r_wr_err;
    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign out_valid = (r_state == ST_STREAM);
    assign out_pixel = out_valid ? w_lane_pix : '0;
    assign out_addr  = out_valid ? r_word : '0;
    assign out_lane  = out_valid ? r_lane : '0;

endmodule

// File: tb/tb_vec_out_mem.sv
// Directed bench for vec_out_mem: a write-vector table with hand-computed word contents,
// then drain sequences checked against those contents plus timing/corner-case sequences.
module tb_vec_out_mem;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        we        = 1'b0;
    logic [23:0] address   = '0;
    logic [23:0] wd        = '0;
    logic [2:0]  wmask     = '0;
    logic        wr_err;
    logic        startIO   = 1'b0;
    logic [23:0] drain_len = '0;
    logic [7:0]  out_pixel;
    logic [23:0] out_addr;
    logic [1:0]  out_lane;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    vec_out_mem #(.ADDR_W(24), .DEPTH(10000), .PIXEL(8), .LANES(3)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .address(address), .wd(wd), .wmask(wmask),
        .wr_err(wr_err), .startIO(startIO), .drain_len(drain_len), .out_pixel(out_pixel),
        .out_addr(out_addr), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] addr;
        logic [23:0] data;
        logic [2:0]  mask;
        logic        exp_err;
        logic [23:0] exp_word;
    } wvec_t;

    wvec_t       wv [13];
    logic [23:0] exp_mem [int];
    logic [7:0]  cap_pix [$];
    logic [23:0] cap_addr [$];
    logic [1:0]  cap_lane [$];
    int errors = 0;
    int checks = 0;
    int done_cnt, valid_cnt, first_busy, first_valid, done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [23:0] a, input logic [23:0] d, input logic [2:0] m,
                            input logic exp_err);
        @(negedge clk);
        we = 1'b1; address = a; wd = d; wmask = m;
        @(negedge clk);
        we = 1'b0;
        chk("wr_err", wr_err, exp_err);
        @(negedge clk);
        chk("wr_err_pulse_end", wr_err, 1'b0);
    endtask

    task automatic run_drain(input logic [23:0] len, input int stall_at, input int budget,
                             input int hold_hi, input logic wr_en, input logic [23:0] wr_addr,
                             input logic [23:0] wr_data);
        int cyc, hs, stall_left;
        bit fin, stalled;
        logic [7:0]  s_pix;
        logic [23:0] s_addr;
        logic [1:0]  s_lane;
        cap_pix.delete(); cap_addr.delete(); cap_lane.delete();
        done_cnt = 0; valid_cnt = 0; first_busy = -1; first_valid = -1; done_cyc = -1;
        cyc = 0; hs = 0; stall_left = 0; fin = 0; stalled = 0;
        s_pix = '0; s_addr = '0; s_lane = '0;
        @(negedge clk);
        drain_len = len; startIO = 1'b1; out_ready = 1'b1;
        if (wr_en) begin
            we = 1'b1; address = wr_addr; wd = wr_data; wmask = 3'b111;
        end
        while ((!fin || cyc < hold_hi + 3) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            we = 1'b0;
            if (cyc >= hold_hi) startIO = 1'b0;
            if (busy && first_busy < 0) first_busy = cyc;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin done_cnt++; if (!fin) done_cyc = cyc; fin = 1; end
            if (out_valid) valid_cnt++;
            if (stall_left > 0) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_pixel", out_pixel, s_pix);
                chk("stall_addr", out_addr, s_addr);
                chk("stall_lane", out_lane, s_lane);
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end else if (!stalled && out_valid && hs == stall_at) begin
                stalled = 1; stall_left = 5; out_ready = 1'b0;
                s_pix = out_pixel; s_addr = out_addr; s_lane = out_lane;
            end
            if (out_valid && out_ready) begin
                cap_pix.push_back(out_pixel);
                cap_addr.push_back(out_addr);
                cap_lane.push_back(out_lane);
                hs++;
            end
        end
        startIO = 1'b0;
        if (!fin) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_stream(input int nwords);
        logic [23:0] ew;
        chk("pixel_count", cap_pix.size(), nwords * 3);
        for (int i = 0; i < cap_pix.size(); i++) begin
            chk("stream_addr", cap_addr[i], i / 3);
            chk("stream_lane", cap_lane[i], i % 3);
            if (exp_mem.exists(i / 3)) begin
                ew = exp_mem[i / 3];
                chk("stream_pixel", cap_pix[i], ew[(i % 3) * 8 +: 8]);
            end
        end
    endtask

    initial begin
        int  cyc, dn;
        bit  found;

        wv[0]  = '{24'd0,       24'hABCDEF, 3'b111, 1'b0, 24'hABCDEF};
        wv[1]  = '{24'd1,       24'h112233, 3'b111, 1'b0, 24'h112233};
        wv[2]  = '{24'd5,       24'h445566, 3'b111, 1'b0, 24'h445566};
        wv[3]  = '{24'd5,       24'h000099, 3'b001, 1'b0, 24'h445599};
        wv[4]  = '{24'd2,       24'h0A0B0C, 3'b111, 1'b0, 24'h0A0B0C};
        wv[5]  = '{24'd2,       24'h777777, 3'b000, 1'b0, 24'h0A0B0C};
        wv[6]  = '{24'd3,       24'h000000, 3'b111, 1'b0, 24'h000000};
        wv[7]  = '{24'd3,       24'hC0FFEE, 3'b101, 1'b0, 24'hC000EE};
        wv[8]  = '{24'd4,       24'h000000, 3'b111, 1'b0, 24'h000000};
        wv[9]  = '{24'd4,       24'hF1E2D3, 3'b010, 1'b0, 24'h00E200};
        wv[10] = '{24'h002710,  24'hDEADBE, 3'b111, 1'b1, 24'h000000};
        wv[11] = '{24'hFFFFFF,  24'h5A5A5A, 3'b111, 1'b1, 24'h000000};
        wv[12] = '{24'd9999,    24'h123456, 3'b111, 1'b0, 24'h123456};

        repeat (3) @(negedge clk);
        chk("rst_wr_err", wr_err, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_pixel", out_pixel, 8'h00);
        chk("rst_out_addr", out_addr, 24'h0);
        chk("rst_out_lane", out_lane, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_write(wv[i].addr, wv[i].data, wv[i].mask, wv[i].exp_err);
            if (!wv[i].exp_err) exp_mem[int'(wv[i].addr)] = wv[i].exp_word;
        end

        // Two-word drain with latency and bubble timing
        run_drain(24'd2, -1, 200, 2, 1'b0, 24'd0, 24'd0);
        chk_stream(2);
        chk("first_busy_cycle", first_busy, 1);
        chk("first_valid_cycle", first_valid, 2);
        chk("done_cycle", done_cyc, 9);
        chk("done_count", done_cnt, 1);
        chk("busy_after", busy, 1'b0);

        run_drain(24'd6, -1, 200, 2, 1'b0, 24'd0, 24'd0);
        chk_stream(6);
        chk("len6_done_count", done_cnt, 1);

        // Backpressure mid-word 1
        run_drain(24'd2, 4, 200, 2, 1'b0, 24'd0, 24'd0);
        chk_stream(2);
        chk("bp_done_count", done_cnt, 1);

        // Write while busy is rejected and leaves memory alone
        fork
            run_drain(24'd3, -1, 200, 2, 1'b0, 24'd0, 24'd0);
            begin
                repeat (4) @(negedge clk);
                do_write(24'd0, 24'h000000, 3'b111, 1'b1);
            end
        join
        chk_stream(3);
        run_drain(24'd1, -1, 200, 2, 1'b0, 24'd0, 24'd0);
        chk_stream(1);

        // Reset during word 1 of a 3-word drain
        dn = 0; found = 0; cyc = 0;
        @(negedge clk);
        drain_len = 24'd3; startIO = 1'b1; out_ready = 1'b1;
        while (!found && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 2) startIO = 1'b0;
            if (done) dn++;
            if (out_valid && out_addr == 24'd1) found = 1;
        end
        startIO = 1'b0;
        chk("rst_reach_word1", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pixel", out_pixel, 8'h00);
        chk("abort_addr", out_addr, 24'h0);
        repeat (3) begin @(negedge clk); if (done) dn++; end
        rst_n = 1'b1;
        repeat (5) begin @(negedge clk); if (done) dn++; end
        chk("abort_no_done", dn, 0);
        chk("abort_idle_busy", busy, 1'b0);
        run_drain(24'd1, -1, 200, 2, 1'b0, 24'd0, 24'd0);
        chk_stream(1);

        run_drain(24'd0, -1, 200, 2, 1'b0, 24'd0, 24'd0);
        chk("len0_done_count", done_cnt, 1);
        chk("len0_done_cycle", done_cyc, 1);
        chk("len0_no_valid", valid_cnt, 0);
        chk("len0_no_busy", first_busy, 32'hFFFFFFFF);

        run_drain(24'd1, -1, 200, 50, 1'b0, 24'd0, 24'd0);
        chk("held_done_count", done_cnt, 1);
        chk_stream(1);

        // Write and start edge in the same cycle: drain sees the new word
        run_drain(24'd2, -1, 200, 2, 1'b1, 24'd1, 24'h5A6B7C);
        exp_mem[1] = 24'h5A6B7C;
        chk_stream(2);

        run_drain(24'd20000, -1, 45000, 2, 1'b0, 24'd0, 24'd0);
        chk_stream(10000);
        chk("big_done_count", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
